// File: rtl/spp_pkg.sv
// spp_pkg: shared types and defaults for the SPP Start/Busy issue controller.
package spp_pkg;
    localparam int SPP_DATA_W = 8;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, HOLD} spp_state_t;
    typedef struct packed {
        logic [SPP_DATA_W-1:0] a;
        logic [SPP_DATA_W-1:0] b;
    } spp_pair_t;
endpackage

// File: rtl/spp_sync_fifo.sv
// spp_sync_fifo: synchronous FIFO with an extra pointer bit to tell full from empty.
module spp_sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;
    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk)
        if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
endmodule

// File: rtl/spp_issue_ctrl.sv
// spp_issue_ctrl: buffers operand pairs and issues them to the engine via Start/Busy.
// Optional per-phase watchdog enabled by SPP_ISSUE_TIMEOUT_EN.
module spp_issue_ctrl
    import spp_pkg::*;
#(
    parameter int DATA_W         = SPP_DATA_W,
    parameter int FIFO_DEPTH     = 4,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              eng_start,
    input  logic              eng_busy,
    output logic [DATA_W-1:0] eng_in_a,
    output logic [DATA_W-1:0] eng_in_b,
    input  logic [DATA_W-1:0] eng_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [CNT_W-1:0]  done_cnt,
    output logic              timeout_err
);
    spp_state_t          state;
    logic                full, empty, pop, in_phase, expired;
    logic [2*DATA_W-1:0] head;

    assign op_ready = !full;
    assign pop      = (state == IDLE) && !empty && !eng_busy && !res_valid;
    assign in_phase = (state == ISSUE) || (state == WAIT_DONE);

    spp_sync_fifo #(.W(2*DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (op_valid && op_ready),
        .pop   (pop),
        .wdata ({op_a, op_b}),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

`ifdef SPP_ISSUE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1) > 8 ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TW-1:0] phase_cnt;
    assign expired = phase_cnt == TW'(TIMEOUT_CYCLES);
    // Counter restarts on every phase entry so each handshake phase gets its own budget.
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            phase_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            phase_cnt <= (pop || !in_phase || (state == ISSUE && eng_busy)) ? '0 : phase_cnt + 1'b1;
            if (in_phase && expired) timeout_err <= 1'b1;
        end
`else
    assign expired     = 1'b0;
    assign timeout_err = TIMEOUT_CYCLES < 0;
`endif

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state     <= IDLE;
            eng_start <= 1'b0;
            eng_in_a  <= '0;
            eng_in_b  <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            done_cnt  <= '0;
        end else if (in_phase && expired) begin
            eng_start <= 1'b0;
            state     <= IDLE;
        end else begin
            case (state)
                IDLE: if (pop) begin
                    {eng_in_a, eng_in_b} <= head;
                    eng_start            <= 1'b1;
                    state                <= ISSUE;
                end
                ISSUE: if (eng_busy) begin
                    eng_start <= 1'b0;
                    state     <= WAIT_DONE;
                end
                WAIT_DONE: if (!eng_busy) begin
                    res_data  <= eng_out;
                    res_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: if (res_ready) begin
                    res_valid <= 1'b0;
                    done_cnt  <= done_cnt + 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_spp_issue_ctrl.sv
// tb_spp_issue_ctrl: directed tests for spp_issue_ctrl against a Start/Busy engine model.
module tb_spp_issue_ctrl;
    logic       clk = 1'b0, reset = 1'b0;
    logic       op_valid = 1'b0, op_ready, eng_start, eng_busy, res_valid, res_ready = 1'b1, timeout_err;
    logic [7:0] op_a = '0, op_b = '0, eng_in_a, eng_in_b, eng_out, res_data;
    logic [3:0] done_cnt;
    logic       m_busy, force_busy = 1'b0, eng_en = 1'b1, prev_start = 1'b0, saw_full = 1'b0;
    logic [7:0] m_out;
    int         m_n, start_viol = 0, tests_run = 0, failed = 0;

    always #5 clk = ~clk;

    spp_issue_ctrl #(.DATA_W(8), .FIFO_DEPTH(4), .CNT_W(4), .TIMEOUT_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .eng_start(eng_start), .eng_busy(eng_busy), .eng_in_a(eng_in_a), .eng_in_b(eng_in_b),
        .eng_out(eng_out), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .done_cnt(done_cnt), .timeout_err(timeout_err)
    );

    // Engine: Busy rises the cycle after Start, stays high 5 cycles, Out = A ^ B.
    assign eng_busy = m_busy | force_busy;
    assign eng_out  = m_out;
    always @(posedge clk or negedge reset)
        if (!reset) begin
            m_busy <= 1'b0;
            m_n    <= 0;
            m_out  <= '0;
        end else if (m_busy) begin
            m_n <= m_n - 1;
            if (m_n == 1) m_busy <= 1'b0;
        end else if (eng_start && eng_en) begin
            m_busy <= 1'b1;
            m_n    <= 5;
            m_out  <= eng_in_a ^ eng_in_b;
        end

    always @(negedge clk) begin
        if (eng_start && !prev_start && eng_busy) start_viol++;
        if (reset && !op_ready) saw_full = 1'b1;
        prev_start = eng_start;
    end

    task automatic push(input logic [7:0] a, input logic [7:0] b);
        int k = 0;
        @(negedge clk);
        op_valid = 1'b1; op_a = a; op_b = b;
        while (!op_ready && k < 200) begin @(negedge clk); k++; end
        if (k >= 200) begin tests_run++; failed++; $display("FAIL push_wait: op_ready=%0b want 1", op_ready); end
        @(posedge clk); #1;
        op_valid = 1'b0;
    endtask

    task automatic get(input logic [7:0] exp);
        int k = 0;
        @(negedge clk);
        while (!res_valid && k < 300) begin @(negedge clk); k++; end
        tests_run++;
        if (!res_valid || res_data !== exp) begin
            failed++; $display("FAIL get_result: valid=%0b data=%h want %h", res_valid, res_data, exp);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++; if (eng_start !== 1'b0) begin failed++; $display("FAIL rst_start: got %b want 0", eng_start); end
        tests_run++; if ({eng_in_a, eng_in_b} !== 16'h0) begin failed++; $display("FAIL rst_operands: got %h want 0000", {eng_in_a, eng_in_b}); end
        tests_run++; if ({res_valid, res_data} !== 9'h0) begin failed++; $display("FAIL rst_result: got %h want 000", {res_valid, res_data}); end
        tests_run++; if ({done_cnt, timeout_err} !== 5'h0) begin failed++; $display("FAIL rst_cnt_err: got %h want 00", {done_cnt, timeout_err}); end
        reset = 1'b1;
        @(negedge clk);
        tests_run++; if (op_ready !== 1'b1) begin failed++; $display("FAIL rst_op_ready: got %b want 1", op_ready); end
    endtask

    task automatic test_single();
        int k = 0;
        push(8'hF0, 8'h0F);
        @(negedge clk);
        tests_run++; if (eng_start !== 1'b0) begin failed++; $display("FAIL single_lat1: start=%b want 0", eng_start); end
        @(negedge clk);
        tests_run++; if (eng_start !== 1'b1) begin failed++; $display("FAIL single_lat2: start=%b want 1", eng_start); end
        while (!eng_busy && k < 20) begin @(negedge clk); k++; end
        tests_run++; if ({eng_busy, eng_start} !== 2'b11) begin failed++; $display("FAIL single_start_held: busy,start=%b want 11", {eng_busy, eng_start}); end
        @(negedge clk);
        tests_run++; if (eng_start !== 1'b0) begin failed++; $display("FAIL single_start_drop: start=%b want 0", eng_start); end
        k = 0;
        while (eng_busy && k < 20) begin @(negedge clk); k++; end
        tests_run++; if ({eng_busy, res_valid} !== 2'b00) begin failed++; $display("FAIL single_busy_fall: busy,valid=%b want 00", {eng_busy, res_valid}); end
        @(negedge clk);
        tests_run++; if ({res_valid, res_data} !== 9'h1FF) begin failed++; $display("FAIL single_result: valid,data=%h want 1ff", {res_valid, res_data}); end
        @(posedge clk); #1;
        tests_run++; if ({res_valid, done_cnt} !== 5'h01) begin failed++; $display("FAIL single_done: valid,cnt=%h want 01", {res_valid, done_cnt}); end
    endtask

    task automatic test_back_to_back();
        saw_full = 1'b0; start_viol = 0;
        fork
            for (int i = 0; i < 6; i++) push(8'hF0 + 8'(i), 8'h0F - 8'(i));
            for (int j = 0; j < 6; j++) get((8'hF0 + 8'(j)) ^ (8'h0F - 8'(j)));
        join
        tests_run++; if (saw_full !== 1'b1) begin failed++; $display("FAIL b2b_op_ready_low: seen=%b want 1", saw_full); end
        tests_run++; if (start_viol !== 0) begin failed++; $display("FAIL b2b_start_while_busy: got %0d want 0", start_viol); end
        tests_run++; if (done_cnt !== 4'd7) begin failed++; $display("FAIL b2b_done_cnt: got %0d want 7", done_cnt); end
    endtask

    task automatic test_backpressure();
        int k = 0, bad = 0;
        logic [7:0] d;
        res_ready = 1'b0;
        push(8'h11, 8'h22);
        push(8'h33, 8'h44);
        @(negedge clk);
        while (!res_valid && k < 100) begin @(negedge clk); k++; end
        d = res_data;
        tests_run++; if ({res_valid, d} !== 9'h133) begin failed++; $display("FAIL bp_first: valid,data=%h want 133", {res_valid, d}); end
        repeat (20) begin
            @(negedge clk);
            if (res_data !== d || !res_valid || eng_start) bad++;
        end
        tests_run++; if (bad !== 0) begin failed++; $display("FAIL bp_hold: %0d bad cycles want 0", bad); end
        res_ready = 1'b1;
        @(posedge clk); #1;
        tests_run++; if ({res_valid, eng_start} !== 2'b00) begin failed++; $display("FAIL bp_accept: valid,start=%b want 00", {res_valid, eng_start}); end
        @(posedge clk); #1;
        tests_run++; if (eng_start !== 1'b1) begin failed++; $display("FAIL bp_next_issue: start=%b want 1", eng_start); end
        get(8'h77);
        tests_run++; if (done_cnt !== 4'd9) begin failed++; $display("FAIL bp_done_cnt: got %0d want 9", done_cnt); end
    endtask

    task automatic test_busy_idle();
        int bad = 0;
        @(negedge clk);
        force_busy = 1'b1;
        push(8'h05, 8'h03);
        repeat (6) begin @(negedge clk); if (eng_start) bad++; end
        tests_run++; if (bad !== 0) begin failed++; $display("FAIL busy_idle_hold: %0d starts want 0", bad); end
        force_busy = 1'b0;
        @(posedge clk); #1;
        tests_run++; if (eng_start !== 1'b1) begin failed++; $display("FAIL busy_idle_release: start=%b want 1", eng_start); end
        get(8'h06);
        tests_run++; if (done_cnt !== 4'd10) begin failed++; $display("FAIL busy_idle_cnt: got %0d want 10", done_cnt); end
    endtask

    task automatic test_reset_mid();
        int k = 0, bad = 0;
        push(8'h01, 8'h02);
        push(8'h03, 8'h04);
        @(negedge clk);
        while (!(eng_busy && !eng_start) && k < 50) begin @(negedge clk); k++; end
        #2 reset = 1'b0;
        #1;
        tests_run++; if ({eng_start, res_valid} !== 2'b00) begin failed++; $display("FAIL rmid_start_valid: got %b want 00", {eng_start, res_valid}); end
        tests_run++; if ({done_cnt, eng_in_a} !== 12'h000) begin failed++; $display("FAIL rmid_cnt_in: got %h want 000", {done_cnt, eng_in_a}); end
        @(negedge clk);
        reset = 1'b1;
        repeat (6) begin @(negedge clk); if (eng_start || !op_ready) bad++; end
        tests_run++; if (bad !== 0) begin failed++; $display("FAIL rmid_fifo_empty: %0d bad cycles want 0", bad); end
    endtask

    task automatic test_wrap();
        for (int i = 1; i <= 17; i++) begin
            push(8'(i), 8'h00);
            get(8'(i));
            if (i == 15) begin tests_run++; if (done_cnt !== 4'hF) begin failed++; $display("FAIL wrap_max: got %0d want 15", done_cnt); end end
            if (i == 16) begin tests_run++; if (done_cnt !== 4'h0) begin failed++; $display("FAIL wrap_zero: got %0d want 0", done_cnt); end end
        end
        tests_run++; if (done_cnt !== 4'd1) begin failed++; $display("FAIL wrap_final: got %0d want 1", done_cnt); end
    endtask

`ifdef SPP_ISSUE_TIMEOUT_EN
    task automatic test_timeout();
        int k = 0, n = 0;
        eng_en = 1'b0;
        push(8'hAA, 8'h55);
        push(8'h12, 8'h34);
        @(negedge clk);
        while (!eng_start && k < 20) begin @(negedge clk); k++; end
        while (eng_start && n < 100) begin n++; @(negedge clk); end
        eng_en = 1'b1;
        tests_run++; if (n !== 11) begin failed++; $display("FAIL to_start_cycles: got %0d want 11", n); end
        tests_run++; if ({timeout_err, res_valid} !== 2'b10) begin failed++; $display("FAIL to_err: err,valid=%b want 10", {timeout_err, res_valid}); end
        get(8'h26);
        tests_run++; if ({timeout_err, done_cnt} !== 5'h12) begin failed++; $display("FAIL to_after: err,cnt=%h want 12", {timeout_err, done_cnt}); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_busy_idle();
        test_reset_mid();
        test_wrap();
`ifdef SPP_ISSUE_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end
endmodule
